// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM encodings, bus-level constants and SCL timing.
package i2c_pkg;

    typedef enum logic [2:0] {
        T_IDLE      = 3'b000,
        T_ADDR      = 3'b001,
        T_ADDR_ACK  = 3'b010,
        T_WRITE     = 3'b011,
        T_WRITE_ACK = 3'b100,
        T_READ      = 3'b101,
        T_READ_ACK  = 3'b110,
        T_IGNORE    = 3'b111
    } target_state_t;

    typedef enum logic [2:0] {
        M_IDLE, M_START, M_ADDR, M_ADDR_ACK, M_WRITE, M_READ, M_DATA_ACK, M_STOP
    } master_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

    // Minimum SCL low time the master guarantees, in clk cycles.
    localparam int I2C_SCL_LOW_CYCLES = 20;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronisers with edge detection and START/STOP recognition.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_pin,
    input  logic sda_pin,
    input  logic sda_drive,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic scl_prev;
    logic sda_prev;
    logic scl;
    logic sda_rise;
    logic sda_fall;

    // Chains reset to the idle-bus level so release from reset makes no edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pin};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pin};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_prev;
    assign scl_fall = ~scl & scl_prev;
    assign sda_rise = sda & ~sda_prev;
    assign sda_fall = ~sda & sda_prev;

    // SCL must be high in both samples, so a coincident SCL edge suppresses START/STOP.
    assign start = sda_fall & scl & scl_prev & ~sda_drive;
    assign stop  = sda_rise & scl & scl_prev & ~sda_drive;

endmodule

// File: rtl/i2c_target.sv
// I2C target engine: address match, ACK generation and byte transfer on an oversampled bus.
module i2c_target
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Scl_Data,
    inout  wire        Sda_Data,
    input  logic [6:0] Target_Address,
    output logic [7:0] Rx_Data,
    output logic       Rx_Valid,
    input  logic       Rx_Nack,
    input  logic [7:0] Tx_Data,
    output logic       Tx_Request,
    output logic       Addr_Match,
    output logic       Rw_Bit,
    output logic       Master_Nack,
    output logic       Start_Det,
    output logic       Stop_Det,
    output logic [2:0] Target_State_Out
);
    localparam int HOLD_W = $clog2(I2C_SCL_LOW_CYCLES);

    target_state_t state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] txsr;
    logic drive;
    logic want;
    logic slot;
    logic nack_r;
    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_pin  (Scl_Data),
        .sda_pin  (Sda_Data),
        .sda_drive(drive),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start_det),
        .stop     (stop_det)
    );

    assign Sda_Data         = drive ? 1'b0 : 1'bz;
    assign Target_State_Out = state;

    // SDA level to apply once the hold delay after an SCL fall expires.
    always_comb begin
        want = 1'b0;
        case (state)
            T_ADDR_ACK:  want = ~slot;
            T_WRITE_ACK: want = ~slot & ~nack_r;
            T_READ:      want = ~txsr[7];
            default:     want = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= T_IDLE;
            drive       <= 1'b0;
            hold_cnt    <= '0;
            bit_cnt     <= '0;
            slot        <= 1'b0;
            nack_r      <= 1'b0;
            shreg       <= '0;
            txsr        <= '0;
            Rx_Data     <= '0;
            Rx_Valid    <= 1'b0;
            Tx_Request  <= 1'b0;
            Addr_Match  <= 1'b0;
            Rw_Bit      <= 1'b0;
            Master_Nack <= 1'b0;
            Start_Det   <= 1'b0;
            Stop_Det    <= 1'b0;
        end else begin
            Rx_Valid    <= 1'b0;
            Tx_Request  <= 1'b0;
            Addr_Match  <= 1'b0;
            Master_Nack <= 1'b0;
            Start_Det   <= 1'b0;
            Stop_Det    <= 1'b0;

            if (Tx_Request) txsr <= Tx_Data;

            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
                if (hold_cnt == HOLD_W'(1)) drive <= want;
            end

            if (start_det) begin
                Start_Det <= 1'b1;
                state     <= T_ADDR;
                bit_cnt   <= '0;
                drive     <= 1'b0;
                hold_cnt  <= '0;
            end else if (stop_det) begin
                Stop_Det <= 1'b1;
                state    <= T_IDLE;
                drive    <= 1'b0;
                hold_cnt <= '0;
            end else if (scl_rise) begin
                case (state)
                    T_ADDR, T_WRITE: begin
                        shreg   <= {shreg[5:0], sda};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            slot <= 1'b0;
                            if (state == T_WRITE) begin
                                Rx_Data  <= {shreg, sda};
                                Rx_Valid <= 1'b1;
                                state    <= T_WRITE_ACK;
                            end else if (shreg == Target_Address) begin
                                Addr_Match <= 1'b1;
                                Rw_Bit     <= sda;
                                state      <= T_ADDR_ACK;
                            end else begin
                                state <= T_IGNORE;
                            end
                        end
                    end
                    T_ADDR_ACK, T_WRITE_ACK: slot <= 1'b1;
                    T_READ_ACK: begin
                        if (sda == I2C_NACK) begin
                            Master_Nack <= 1'b1;
                            state       <= T_IGNORE;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                hold_cnt <= HOLD_W'(HOLD_CYCLES);
                case (state)
                    T_ADDR_ACK: begin
                        if (slot) begin
                            bit_cnt <= '0;
                            if (Rw_Bit == I2C_RW_READ) begin
                                state      <= T_READ;
                                Tx_Request <= 1'b1;
                            end else begin
                                state <= T_WRITE;
                            end
                        end
                    end
                    T_WRITE_ACK: begin
                        if (!slot) begin
                            nack_r <= Rx_Nack;
                        end else begin
                            bit_cnt <= '0;
                            state   <= nack_r ? T_IGNORE : T_WRITE;
                        end
                    end
                    T_READ: begin
                        if (bit_cnt == 3'd7) begin
                            state <= T_READ_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txsr    <= {txsr[6:0], 1'b0};
                        end
                    end
                    T_READ_ACK: begin
                        state      <= T_READ;
                        Tx_Request <= 1'b1;
                        bit_cnt    <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged master drives the bus, checks use immediate assertions.
module tb_i2c_target;
    localparam int Q = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic       rx_nack = 1'b0;
    logic [6:0] taddr = 7'h44;
    logic [7:0] tx_data;
    wire        sda;

    logic [7:0] Rx_Data;
    logic       Rx_Valid, Tx_Request, Addr_Match, Rw_Bit, Master_Nack, Start_Det, Stop_Det;
    logic [2:0] state;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_target dut (
        .clk             (clk),
        .rst             (rst),
        .Scl_Data        (scl),
        .Sda_Data        (sda),
        .Target_Address  (taddr),
        .Rx_Data         (Rx_Data),
        .Rx_Valid        (Rx_Valid),
        .Rx_Nack         (rx_nack),
        .Tx_Data         (tx_data),
        .Tx_Request      (Tx_Request),
        .Addr_Match      (Addr_Match),
        .Rw_Bit          (Rw_Bit),
        .Master_Nack     (Master_Nack),
        .Start_Det       (Start_Det),
        .Stop_Det        (Stop_Det),
        .Target_State_Out(state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_match, n_rxv, n_treq, n_mnack, n_start, n_stop, n_low;
    logic [7:0] last_rx;
    logic [7:0] tx_seq [8] = '{8'h66, 8'h8A, 8'h9B, 8'h12, 8'h34, 8'h56, 8'hC3, 8'h00};
    int  tx_idx = 0;
    bit  tx_adv = 0;

    // Pulse counters and the Tx_Data feeder; Tx_Data advances only after the capture edge.
    always @(negedge clk) begin
        if (tx_adv && tx_idx < 7) begin
            tx_idx  = tx_idx + 1;
            tx_data = tx_seq[tx_idx];
        end
        tx_adv  = Tx_Request;
        n_treq  += int'(Tx_Request);
        n_match += int'(Addr_Match);
        n_rxv   += int'(Rx_Valid);
        n_mnack += int'(Master_Nack);
        n_start += int'(Start_Det);
        n_stop  += int'(Stop_Det);
        if (Rx_Valid) last_rx = Rx_Data;
        if (sda === 1'b0 && !m_low) n_low++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_match = 0; n_rxv = 0; n_treq = 0; n_mnack = 0;
        n_start = 0; n_stop = 0; n_low = 0;
    endtask

    task automatic mbit(input logic b, output logic r);
        cyc(Q); m_low = ~b;
        cyc(Q); scl = 1'b1;
        cyc(Q); r = sda;
        cyc(Q); scl = 1'b0;
    endtask

    task automatic mstart();
        if (scl == 1'b0) begin
            cyc(Q); m_low = 1'b0;
            cyc(Q); scl = 1'b1;
            cyc(Q);
        end
        m_low = 1'b1;
        cyc(Q); scl = 1'b0;
    endtask

    task automatic mstop();
        cyc(Q); m_low = 1'b1;
        cyc(Q); scl = 1'b1;
        cyc(Q); m_low = 1'b0;
        cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) mbit(b[i], r);
        mbit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            mbit(1'b1, r);
            v[i] = r;
        end
        mbit(~nack ? 1'b0 : 1'b1, r);
    endtask

    initial begin
        logic       a;
        logic [7:0] v;
        logic [7:0] exp_rd [6] = '{8'h66, 8'h8A, 8'h9B, 8'h12, 8'h34, 8'h56};
        tx_data = 8'h66;
        clear_counts();

        // Reset values
        cyc(5);
        chk("rst state", 32'(state), 32'h0);
        chk("rst rx_data", 32'(Rx_Data), 32'h0);
        chk("rst rw_bit", 32'(Rw_Bit), 32'h0);
        chk("rst pulses", 32'({Rx_Valid, Tx_Request, Addr_Match, Master_Nack, Start_Det, Stop_Det}), 32'h0);
        chk("rst sda", 32'(sda), 32'h1);
        rst = 1'b0;
        cyc(5);

        // 1: write 0xFD to 0x44
        clear_counts();
        mstart();
        write_byte(8'h88, a);
        chk("t1 addr ack", 32'(a), 32'h0);
        cyc(4);
        chk("t1 state write", 32'(state), 32'h3);
        write_byte(8'hFD, a);
        chk("t1 data ack", 32'(a), 32'h0);
        chk("t1 rx count", 32'(n_rxv), 32'd1);
        chk("t1 rx data", 32'(last_rx), 32'hFD);
        chk("t1 match count", 32'(n_match), 32'd1);
        chk("t1 rw_bit", 32'(Rw_Bit), 32'h0);
        mstop();
        cyc(4);
        chk("t1 stop count", 32'(n_stop), 32'd1);
        chk("t1 start count", 32'(n_start), 32'd1);
        chk("t1 state idle", 32'(state), 32'h0);

        // 2: foreign address 0x45 is ignored
        clear_counts();
        mstart();
        write_byte(8'h8A, a);
        chk("t2 addr nack", 32'(a), 32'h1);
        cyc(4);
        chk("t2 state ignore", 32'(state), 32'h7);
        write_byte(8'h55, a);
        chk("t2 data nack", 32'(a), 32'h1);
        chk("t2 state still ignore", 32'(state), 32'h7);
        mstop();
        cyc(4);
        chk("t2 state idle", 32'(state), 32'h0);
        chk("t2 sda never driven", 32'(n_low), 32'd0);
        chk("t2 match count", 32'(n_match), 32'd0);
        chk("t2 rx count", 32'(n_rxv), 32'd0);

        // 3: six-byte read, master NACKs the last
        clear_counts();
        mstart();
        write_byte(8'h89, a);
        chk("t3 addr ack", 32'(a), 32'h0);
        for (int k = 0; k < 6; k++) begin
            read_byte(k == 5, v);
            chk($sformatf("t3 read byte %0d", k), 32'(v), 32'(exp_rd[k]));
        end
        cyc(4);
        chk("t3 tx_request count", 32'(n_treq), 32'd6);
        chk("t3 master_nack count", 32'(n_mnack), 32'd1);
        chk("t3 state ignore", 32'(state), 32'h7);
        chk("t3 rw_bit", 32'(Rw_Bit), 32'h1);
        mstop();
        cyc(4);
        chk("t3 state idle", 32'(state), 32'h0);

        // 4: repeated START after 3 data bits, then a read
        clear_counts();
        mstart();
        write_byte(8'h88, a);
        chk("t4 addr ack", 32'(a), 32'h0);
        mbit(1'b1, a);
        mbit(1'b0, a);
        mbit(1'b1, a);
        mstart();
        cyc(4);
        chk("t4 start count", 32'(n_start), 32'd2);
        chk("t4 no rx_valid", 32'(n_rxv), 32'd0);
        chk("t4 state addr", 32'(state), 32'h1);
        write_byte(8'h89, a);
        chk("t4 read addr ack", 32'(a), 32'h0);
        cyc(4);
        chk("t4 state read", 32'(state), 32'h5);
        chk("t4 rw_bit", 32'(Rw_Bit), 32'h1);
        read_byte(1'b1, v);
        chk("t4 read byte", 32'(v), 32'hC3);
        mstop();
        cyc(4);

        // 5: reset while the target drives the address ACK
        clear_counts();
        mstart();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] ab;
            ab = 8'h89;
            mbit(ab[i], a);
        end
        cyc(Q); m_low = 1'b0;
        cyc(Q); scl = 1'b1;
        cyc(Q / 2);
        chk("t5 ack driven", 32'(sda), 32'h0);
        chk("t5 state addr_ack", 32'(state), 32'h2);
        rst = 1'b1;
        cyc(1);
        chk("t5 sda released", 32'(sda), 32'h1);
        chk("t5 state", 32'(state), 32'h0);
        chk("t5 rx_data", 32'(Rx_Data), 32'h0);
        chk("t5 rw_bit", 32'(Rw_Bit), 32'h0);
        chk("t5 pulses", 32'({Rx_Valid, Tx_Request, Addr_Match, Master_Nack, Start_Det, Stop_Det}), 32'h0);
        rst = 1'b0;
        cyc(Q); scl = 1'b0;
        mstop();
        cyc(4);
        chk("t5 state after stop", 32'(state), 32'h0);

        // 6: Rx_Nack during write byte 0x0A
        clear_counts();
        mstart();
        write_byte(8'h88, a);
        chk("t6 addr ack", 32'(a), 32'h0);
        rx_nack = 1'b1;
        write_byte(8'h0A, a);
        rx_nack = 1'b0;
        chk("t6 data nack", 32'(a), 32'h1);
        chk("t6 rx count", 32'(n_rxv), 32'd1);
        chk("t6 rx data", 32'(last_rx), 32'h0A);
        cyc(4);
        chk("t6 state ignore", 32'(state), 32'h7);
        mstop();
        cyc(4);
        chk("t6 state idle", 32'(state), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
Synchronous I2C target (peripheral) engine. It is the responder end for i2c_master and serves as an SHT40-style sensor model in benches and as a target core in FPGA builds. It oversamples Scl_Data/Sda_Data on clk, detects START/STOP, matches a 7-bit address, ACKs, and moves bytes to and from a parallel byte interface. SDA is open-drain: the block only ever drives 0 or Z.

Parameters:
SYNC_STAGES, 2, synchroniser depth on SCL and SDA inputs (min 2)
HOLD_CYCLES, 5, clk cycles after a detected SCL falling edge before the target changes SDA (must be < 20, the master's minimum SCL-low time)

Ports:
clk  in  1  system clock, sole clock
rst  in  1  synchronous, active-high reset
Scl_Data  in  1  bus SCL (target never stretches)
Sda_Data  inout  1  bus SDA; driven 1'b0 or 1'bZ only
Target_Address  in  7  address to respond to; static during a transfer
Rx_Data  out  8  last byte written by master, MSB received first
Rx_Valid  out  1  1-cycle pulse, Rx_Data valid
Rx_Nack  in  1  1 = NACK the byte currently being received (sampled at ACK slot)
Tx_Data  in  8  next byte to send to master
Tx_Request  out  1  1-cycle pulse; Tx_Data captured on the following clk edge
Addr_Match  out  1  1-cycle pulse on address match
Rw_Bit  out  1  R/W bit of last matched address (1 = read)
Master_Nack  out  1  1-cycle pulse when master NACKs a read byte
Start_Det  out  1  1-cycle pulse on START or repeated START
Stop_Det  out  1  1-cycle pulse on STOP
Target_State_Out  out  3  current FSM state

Behaviour:
- Reset: state IDLE, SDA = Z, all pulses 0, Rx_Data = 0, Rw_Bit = 0, bit counter = 0. rst mid-transfer releases SDA on the next clk edge.
- Edges are taken from the synchronised SCL/SDA; latency is SYNC_STAGES+1 clk from pin to edge detect.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are masked while the target drives SDA. If the SCL and SDA edges are detected in the same cycle, the SCL edge wins and no START/STOP is flagged.
- START from any state: Start_Det pulses, bit counter is cleared, state goes to ADDR, and any partial byte is discarded (no Rx_Valid). STOP from any state: Stop_Det pulses, SDA is released, state goes to IDLE.
- Data bits are sampled on the SCL rising edge, MSB first, with a 3-bit counter. The target changes SDA only HOLD_CYCLES after an SCL falling edge.
- States:
  - IDLE 000: wait for START.
  - ADDR 001: shift 8 bits. If [7:1] == Target_Address, pulse Addr_Match, latch Rw_Bit, go to ADDR_ACK. Otherwise go to IGNORE. General call (0x00) is not supported.
  - ADDR_ACK 010: drive 0 for the 9th clock. On the following SCL fall, go to WRITE (Rw=0) or READ (Rw=1). For READ, Tx_Request pulses on the cycle of that SCL fall.
  - WRITE 011: shift 8 bits. One cycle after the 8th rising edge, Rx_Valid pulses with Rx_Data. Go to WRITE_ACK.
  - WRITE_ACK 100: drive 0 if Rx_Nack=0, else leave Z and go to IGNORE after the slot. On the SCL fall, release and go to WRITE.
  - READ 101: drive the latched byte MSB first (1 bits = Z). After the 8th SCL fall, release SDA and go to READ_ACK.
  - READ_ACK 110: sample SDA at SCL rise. 0 = ACK: pulse Tx_Request at the SCL fall, then return to READ. 1 = NACK: pulse Master_Nack and go to IGNORE.
  - IGNORE 111: SDA Z; wait for START/STOP.
- The target never stretches SCL and never detects arbitration loss.

Decomposition:
- Shared package i2c_pkg holds:
  - state encodings for master and target;
  - I2C_RW_WRITE/I2C_RW_READ;
  - the ACK/NACK level constants;
  - the 20-cycle SCL timing constant.
- One natural sub-module, i2c_line_sync: synchronisers, SCL rise/fall detect, START/STOP detect with SDA-drive mask input.

Test Plan:
1. Target_Address=0x44; START, 0x88 (0x44,W), 0xFD, STOP -> SDA=0 during both 9th clocks; Addr_Match once, Rw_Bit=0; one Rx_Valid with Rx_Data=0xFD; Stop_Det once; state 000.
2. Master addresses 0x45 -> target never drives SDA; no Addr_Match/Rx_Valid; state 111 until STOP, then 000.
3. Read 0x89, Tx_Data sequence 0x66,0x8A,0x9B,0x12,0x34,0x56; master ACKs 5 bytes and NACKs the 6th -> bits appear MSB first on SCL high; 6 Tx_Request pulses; Master_Nack once; state 111, then 000 at STOP.
4. Repeated START after 3 data bits of a write -> Start_Det pulse, no Rx_Valid; state 001; next address 0x89 accepted as a read.
5. rst asserted while the target is driving the address ACK -> SDA = Z the next cycle; all outputs at reset values; state 000.
6. Rx_Nack=1 during write byte 0x0A -> Rx_Valid with 0x0A; 9th bit SDA high; state 111.
